// File: rtl/fft_tw_addr_gen.sv
// Stage/butterfly sequencer for an in-place radix-2 DIF FFT. It drives the twiddle ROM and
// delays the butterfly indices by one cycle so they line up with the ROM output.
module fft_tw_addr_gen #(
  parameter int N_LOG2     = 9,
  parameter int ADDR_WIDTH = N_LOG2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rom_rd_en,
  output logic [ADDR_WIDTH-1:0]     rom_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_LOG2-1:0]         idx_a,
  output logic [N_LOG2-1:0]         idx_b,
  output logic [$clog2(N_LOG2)-1:0] stage
);

  localparam int SW = $clog2(N_LOG2);
  localparam int KW = N_LOG2 - 1;
  localparam logic [KW-1:0]     K_LAST = '1;
  localparam logic [SW-1:0]     S_LAST = SW'(N_LOG2 - 1);
  localparam logic [N_LOG2-1:0] ONE    = N_LOG2'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [KW-1:0]     k_q, k_d;
  logic              out_valid_q, out_valid_d;
  logic [N_LOG2-1:0] idx_a_q, idx_a_d;
  logic [N_LOG2-1:0] idx_b_q, idx_b_d;
  logic [SW-1:0]     stage_q, stage_d;

  logic [31:0]       sh_lo, sh_hi;
  logic [N_LOG2-1:0] k_ext, h, j, g, cur_a, cur_b, tw;
  logic              issue, last_item;

  // Butterfly geometry for the item that the (s, k) counters currently point at
  always_comb begin
    sh_lo = 32'(N_LOG2 - 1) - 32'(s_q);
    sh_hi = sh_lo + 32'd1;
    k_ext = {1'b0, k_q};
    h     = ONE << sh_lo;
    j     = k_ext & (h - ONE);
    g     = k_ext >> sh_lo;
    cur_a = (g << sh_hi) | j;
    cur_b = cur_a + h;
    tw    = j << s_q;
  end

  assign issue     = (state_q == RUN) && (!out_valid_q || out_ready);
  assign last_item = (s_q == S_LAST) && (k_q == K_LAST);

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    idx_a_d     = idx_a_q;
    idx_b_d     = idx_b_q;
    stage_d     = stage_q;

    if (!issue && out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        if (issue) begin
          idx_a_d     = cur_a;
          idx_b_d     = cur_b;
          stage_d     = s_q;
          out_valid_d = 1'b1;
          // Counters return to zero after the last item so rom_addr idles at 0
          if (last_item) begin
            s_d     = '0;
            k_d     = '0;
            state_d = DRAIN;
          end else if (k_q == K_LAST) begin
            k_d = '0;
            s_d = s_q + SW'(1);
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      idx_a_q     <= '0;
      idx_b_q     <= '0;
      stage_q     <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      idx_a_q     <= idx_a_d;
      idx_b_q     <= idx_b_d;
      stage_q     <= stage_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign rom_rd_en = issue;
  assign rom_addr  = ADDR_WIDTH'(tw);
  assign out_valid = out_valid_q;
  assign idx_a     = idx_a_q;
  assign idx_b     = idx_b_q;
  assign stage     = stage_q;

endmodule

// File: tb/tb_fft_tw_addr_gen.sv
// Directed bench for fft_tw_addr_gen: an 8-point instance with a small twiddle ROM model,
// plus the default 512-point instance for the full-length pass.
module tb_fft_tw_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 8-point instance
  logic       s_start, s_ready, s_busy, s_done, s_rd_en, s_valid;
  logic [2:0] s_addr, s_a, s_b;
  logic [1:0] s_stage;
  logic [15:0] s_rom_q;

  // 512-point instance
  logic       b_start, b_ready, b_busy, b_done, b_rd_en, b_valid;
  logic [8:0] b_addr, b_a, b_b;
  logic [3:0] b_stage;
  logic [15:0] b_rom_q;

  fft_tw_addr_gen #(.N_LOG2(3), .ADDR_WIDTH(3)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .rom_rd_en(s_rd_en), .rom_addr(s_addr), .out_valid(s_valid), .out_ready(s_ready),
    .idx_a(s_a), .idx_b(s_b), .stage(s_stage)
  );

  fft_tw_addr_gen dut_big (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .rom_rd_en(b_rd_en), .rom_addr(b_addr), .out_valid(b_valid), .out_ready(b_ready),
    .idx_a(b_a), .idx_b(b_b), .stage(b_stage)
  );

  function automatic logic [15:0] rom_val(input logic [8:0] a);
    return ({7'd0, a} * 16'd7) + 16'd100;
  endfunction

  // Twiddle ROM stand-ins: data registered one edge after rd_en
  always @(posedge clk) begin
    if (s_rd_en) s_rom_q <= rom_val({6'd0, s_addr});
    if (b_rd_en) b_rom_q <= rom_val(b_addr);
  end

  int total_checks  = 0;
  int passed_checks = 0;
  int failed_checks = 0;

  int exp_a    [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int exp_b    [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int exp_addr [12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else begin
      failed_checks++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 8-point pass: checks every issue address and every handshake against the tables
  task automatic applyStimulus(input bit do_start, input bit rand_ready, input bit poke_start);
    int hs_n    = 0;
    int is_n    = 0;
    int last_hs = -10;
    bit seen    = 1'b0;
    if (do_start) begin
      s_start = 1'b1;
      step();
      s_start = 1'b0;
    end
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      s_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_start) s_start = (cyc == 5);
      #1;
      if (s_done) begin
        checkOutput("done_item_count", 32'(hs_n), 32'd12);
        checkOutput("done_latency", 32'(cyc), 32'(last_hs + 1));
        seen = 1'b1;
      end else begin
        if (s_rd_en || (s_valid && !s_ready && is_n < 12)) begin
          if (is_n < 12) checkOutput("rom_addr", 32'(s_addr), 32'(exp_addr[is_n]));
          else           checkOutput("extra_issue", 32'(s_rd_en), 32'd0);
        end
        if (s_rd_en && is_n < 12) is_n++;
        if (s_valid && s_ready) begin
          if (hs_n < 12) begin
            checkOutput("idx_a", 32'(s_a), 32'(exp_a[hs_n]));
            checkOutput("idx_b", 32'(s_b), 32'(exp_b[hs_n]));
            checkOutput("stage", 32'(s_stage), 32'(hs_n / 4));
            checkOutput("out_real", 32'(s_rom_q), 32'(rom_val(9'(exp_addr[hs_n]))));
            if (!rand_ready) checkOutput("throughput", 32'(cyc), 32'(hs_n + 1));
          end else begin
            checkOutput("extra_item", 32'(s_valid), 32'd0);
          end
          last_hs = cyc;
          hs_n++;
        end
        step();
      end
    end
    if (!seen) checkOutput("done_timeout", 32'(s_done), 32'd1);
    if (poke_start) s_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hs;
    int last_hs;
    int last_a, last_b, last_st, last_real, first_a, first_b;
    bit seen;

    rst = 1'b1; s_start = 1'b0; s_ready = 1'b1; b_start = 1'b0; b_ready = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    step();

    checkOutput("reset_busy",  32'(s_busy),  32'd0);
    checkOutput("reset_done",  32'(s_done),  32'd0);
    checkOutput("reset_valid", 32'(s_valid), 32'd0);
    checkOutput("reset_rd_en", 32'(s_rd_en), 32'd0);
    checkOutput("reset_addr",  32'(s_addr),  32'd0);
    checkOutput("reset_idx_a", 32'(s_a),     32'd0);
    checkOutput("reset_idx_b", 32'(s_b),     32'd0);
    checkOutput("reset_stage", 32'(s_stage), 32'd0);
    checkOutput("reset_big_busy", 32'(b_busy), 32'd0);

    $display("[TB] reset in the middle of a pass");
    s_start = 1'b1; step(); s_start = 1'b0;
    step(); step(); step();
    checkOutput("mid_run_busy",  32'(s_busy),  32'd1);
    checkOutput("mid_run_valid", 32'(s_valid), 32'd1);
    rst = 1'b1;
    step();
    checkOutput("rst_busy",  32'(s_busy),  32'd0);
    checkOutput("rst_valid", 32'(s_valid), 32'd0);
    checkOutput("rst_rd_en", 32'(s_rd_en), 32'd0);
    step(); step();
    rst = 1'b0;
    step();
    checkOutput("post_rst_busy", 32'(s_busy), 32'd0);
    checkOutput("post_rst_addr", 32'(s_addr), 32'd0);

    $display("[TB] clean pass, out_ready held high");
    applyStimulus(1'b1, 1'b0, 1'b0);
    step();

    $display("[TB] random backpressure passes");
    applyStimulus(1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0);
    s_ready = 1'b1;
    step();

    $display("[TB] start pulsed during RUN");
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("single_done", 32'(s_done), 32'd0);
      checkOutput("stays_idle",  32'(s_busy), 32'd0);
    end

    $display("[TB] start held high, back-to-back passes");
    s_start = 1'b1;
    step();
    applyStimulus(1'b0, 1'b0, 1'b0);
    step();
    checkOutput("idle_gap_busy", 32'(s_busy), 32'd0);
    step();
    checkOutput("restart_busy", 32'(s_busy), 32'd1);
    s_start = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    step();

    $display("[TB] full 512-point pass");
    b_ready = 1'b1;
    b_start = 1'b1; step(); b_start = 1'b0;
    hs = 0; last_hs = -10; seen = 1'b0;
    last_a = 0; last_b = 0; last_st = 0; last_real = 0; first_a = -1; first_b = -1;
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      if (b_done) begin
        checkOutput("big_item_count", 32'(hs), 32'd2304);
        checkOutput("big_done_latency", 32'(cyc), 32'(last_hs + 1));
        checkOutput("big_total_cycles", 32'(cyc), 32'd2305);
        checkOutput("big_last_idx_a", 32'(last_a), 32'd510);
        checkOutput("big_last_idx_b", 32'(last_b), 32'd511);
        checkOutput("big_last_stage", 32'(last_st), 32'd8);
        checkOutput("big_last_real", 32'(last_real), 32'(rom_val(9'd0)));
        checkOutput("big_first_idx_a", 32'(first_a), 32'd0);
        checkOutput("big_first_idx_b", 32'(first_b), 32'd256);
        seen = 1'b1;
      end else begin
        if (b_valid) begin
          if (hs == 0) begin
            first_a = int'(b_a);
            first_b = int'(b_b);
          end
          last_a = int'(b_a); last_b = int'(b_b); last_st = int'(b_stage);
          last_real = int'(b_rom_q);
          last_hs = cyc;
          hs++;
        end
        step();
      end
    end
    if (!seen) checkOutput("big_done_timeout", 32'(b_done), 32'd1);
    step();
    checkOutput("big_idle_after", 32'(b_busy), 32'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
